// File: rtl/pairing_job_arbiter_pkg.sv
// pairing_job_arbiter_pkg
//   Shared definitions for the pairing job arbiter and its sub-modules:
//   operand/result widths of the F3m pairing datapath, the FSM state
//   encoding, the default watchdog limit and a helper that sizes the
//   watchdog counter.
//   No ports (package).
package pairing_job_arbiter_pkg;

  // F3m element width (two bits per trit) and sextic-extension result width.
  localparam int WIDTH = 193;
  localparam int W6    = 1163;

  localparam int TIMEOUT_DEFAULT = 65535;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } arb_state_e;

  // Watchdog counter width: enough bits for the limit, kept within 16..32.
  function automatic int wd_cnt_width(input int limit);
    int bits;
    bits = $clog2(limit);
    if (bits < 16) begin
      return 16;
    end else if (bits > 32) begin
      return 32;
    end else begin
      return bits;
    end
  endfunction

endpackage

// File: rtl/pairing_job_arbiter_if.sv
// pairing_job_arbiter_if
//   Host-side job bus of the pairing arbiter.
//   Request side : req_valid / req_ready (one bit per requester) and the
//                  flattened operands req_x1/req_y1/req_x2/req_y2, slice k
//                  belonging to requester k.
//   Result side  : res_valid / res_ready handshake carrying res_id,
//                  res_data and res_err.
//   Modports: master = host/requesters, slave = arbiter.
interface pairing_job_arbiter_if
  import pairing_job_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ-1:0]           req_ready;
  logic [N_REQ*(WIDTH+1)-1:0] req_x1;
  logic [N_REQ*(WIDTH+1)-1:0] req_y1;
  logic [N_REQ*(WIDTH+1)-1:0] req_x2;
  logic [N_REQ*(WIDTH+1)-1:0] req_y2;
  logic                       res_valid;
  logic                       res_ready;
  logic [ID_W-1:0]            res_id;
  logic [W6:0]                res_data;
  logic                       res_err;

  modport master (
    output req_valid, req_x1, req_y1, req_x2, req_y2, res_ready,
    input  req_ready, res_valid, res_id, res_data, res_err
  );

  modport slave (
    input  req_valid, req_x1, req_y1, req_x2, req_y2, res_ready,
    output req_ready, res_valid, res_id, res_data, res_err
  );

endinterface

// File: rtl/pairing_job_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker, reusable by any shared F3m resource.
//   Ports:
//     req  [N_REQ] in  : pending requests
//     ptr  [ID_W]  in  : highest-priority index
//     grant[N_REQ] out : one-hot grant (all zero when nothing requests)
//     gidx [ID_W]  out : index of the granted requester
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gidx
);

  logic found;
  int   idx;

  // Scan from ptr upward, wrapping; the first set request wins.
  always_comb begin
    grant = {N_REQ{1'b0}};
    gidx  = {ID_W{1'b0}};
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = ID_W'(idx);
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/pairing_job_arbiter.sv
// pairing_job_arbiter
//   Shares one tate_pairing core among N_REQ requesters: round-robin grant,
//   operand capture/hold, core restart sequencing and result return with
//   requester id and backpressure. One job at a time.
//   Optional watchdog: define PAIRING_TIMEOUT_EN to abort a job that runs
//   TIMEOUT_CYCLES cycles without core_done (result returned with res_err=1).
//   Ports:
//     clk, reset        : clock, synchronous active-high reset
//     job (slave)       : host request/result bus (pairing_job_arbiter_if)
//     busy              : a job is held (state other than IDLE)
//     core_reset        : core reset, low only while the core runs
//     core_x1..core_y2  : captured operands to the core
//     core_done,core_out: core completion and result
module pairing_job_arbiter
  import pairing_job_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  pairing_job_arbiter_if.slave    job,
  output logic                    busy,
  output logic                    core_reset,
  output logic [WIDTH:0]          core_x1,
  output logic [WIDTH:0]          core_y1,
  output logic [WIDTH:0]          core_x2,
  output logic [WIDTH:0]          core_y2,
  input  logic                    core_done,
  input  logic [W6:0]             core_out
);

  localparam int OPW = WIDTH + 1;

  if (N_REQ < 2 || N_REQ > 8 || (1 << ID_W) < N_REQ) begin : g_bad_cfg
    $error("pairing_job_arbiter: N_REQ must be 2..8 and fit in ID_W bits");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pairing_job_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e       state_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  res_id_r;
  logic [W6:0]      res_data_r;
  logic             res_valid_r;
  logic             busy_r;
  logic             core_reset_r;
  logic [WIDTH:0]   x1_r, y1_r, x2_r, y2_r;
  logic [N_REQ-1:0] grant_s;
  logic [ID_W-1:0]  gidx_s;
  logic             accept_s;

`ifdef PAIRING_TIMEOUT_EN
  localparam int CNT_W = wd_cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wd_cnt_r;
  logic             res_err_r;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (job.req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .gidx  (gidx_s)
  );

  // The grant is a same-cycle accept, so it cannot be registered; it is
  // suppressed while reset is high because the capture would be discarded.
  assign accept_s      = (state_r == S_IDLE) && !reset && (|job.req_valid);
  assign job.req_ready = accept_s ? grant_s : {N_REQ{1'b0}};

  assign job.res_valid = res_valid_r;
  assign job.res_id    = res_id_r;
  assign job.res_data  = res_data_r;
`ifdef PAIRING_TIMEOUT_EN
  assign job.res_err   = res_err_r;
`else
  assign job.res_err   = 1'b0;
`endif
  assign busy       = busy_r;
  assign core_reset = core_reset_r;
  assign core_x1    = x1_r;
  assign core_y1    = y1_r;
  assign core_x2    = x2_r;
  assign core_y2    = y2_r;

  // Job FSM with registered outputs; core_reset is low only in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_IDLE;
      rr_ptr_r     <= {ID_W{1'b0}};
      res_id_r     <= {ID_W{1'b0}};
      res_data_r   <= {(W6+1){1'b0}};
      res_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      core_reset_r <= 1'b1;
      x1_r         <= {OPW{1'b0}};
      y1_r         <= {OPW{1'b0}};
      x2_r         <= {OPW{1'b0}};
      y2_r         <= {OPW{1'b0}};
`ifdef PAIRING_TIMEOUT_EN
      wd_cnt_r     <= {CNT_W{1'b0}};
      res_err_r    <= 1'b0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            x1_r         <= job.req_x1[int'(gidx_s)*OPW +: OPW];
            y1_r         <= job.req_y1[int'(gidx_s)*OPW +: OPW];
            x2_r         <= job.req_x2[int'(gidx_s)*OPW +: OPW];
            y2_r         <= job.req_y2[int'(gidx_s)*OPW +: OPW];
            res_id_r     <= gidx_s;
            rr_ptr_r     <= (gidx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}}
                                                         : gidx_s + ID_W'(1);
            busy_r       <= 1'b1;
            core_reset_r <= 1'b1;
            state_r      <= S_START;
          end
        end
        S_START: begin
          // Operands are already on core_*; release the core next cycle.
          core_reset_r <= 1'b0;
`ifdef PAIRING_TIMEOUT_EN
          wd_cnt_r     <= {CNT_W{1'b0}};
`endif
          state_r      <= S_RUN;
        end
        S_RUN: begin
          if (core_done) begin
            res_data_r   <= core_out;
            res_valid_r  <= 1'b1;
            core_reset_r <= 1'b1;
`ifdef PAIRING_TIMEOUT_EN
            res_err_r    <= 1'b0;
`endif
            state_r      <= S_RESP;
          end
`ifdef PAIRING_TIMEOUT_EN
          else if (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            res_data_r   <= {(W6+1){1'b0}};
            res_err_r    <= 1'b1;
            res_valid_r  <= 1'b1;
            core_reset_r <= 1'b1;
            state_r      <= S_RESP;
          end else begin
            wd_cnt_r     <= wd_cnt_r + CNT_W'(1);
          end
`endif
        end
        S_RESP: begin
          if (job.res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          res_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
          core_reset_r <= 1'b1;
          state_r      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pairing_job_arbiter.sv
// tb_pairing_job_arbiter
//   Self-checking bench for pairing_job_arbiter with N_REQ=4 and a core model
//   raising done 20 cycles after its reset falls, out = x1^y1^x2^y2.
//   Build with PAIRING_TIMEOUT_EN to add the watchdog scenario (limit 8).
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pairing_job_arbiter;
  import pairing_job_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int OPW = WIDTH + 1;
`ifdef PAIRING_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 65535;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pairing_job_arbiter_if #(.N_REQ(N), .ID_W(IDW)) job();

  logic           busy, core_reset, core_done;
  logic [WIDTH:0] core_x1, core_y1, core_x2, core_y2;
  logic [W6:0]    core_out;
  int             core_cnt = 0;
  logic           core_hang = 1'b0;
  int             total = 0;
  int             bad = 0;

  // Core model: counts cycles since its reset fell.
  always @(posedge clk) core_cnt <= core_reset ? 0 : core_cnt + 1;
  assign core_done = !core_reset && !core_hang && (core_cnt == 20);
  assign core_out  = {{(W6-WIDTH){1'b0}}, core_x1 ^ core_y1 ^ core_x2 ^ core_y2};

  pairing_job_arbiter #(.N_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .job        (job),
    .busy       (busy),
    .core_reset (core_reset),
    .core_x1    (core_x1),
    .core_y1    (core_y1),
    .core_x2    (core_x2),
    .core_y2    (core_y2),
    .core_done  (core_done),
    .core_out   (core_out)
  );

  function automatic logic [WIDTH:0] rand_op();
    logic [WIDTH:0] r;
    for (int i = 0; i <= WIDTH; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  // Round-robin rule: first set bit at or after ptr, wrapping.
  function automatic int rr_expect(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic set_ops(input int k, input logic [WIDTH:0] a, b, c, d);
    job.req_x1[k*OPW +: OPW] = a;
    job.req_y1[k*OPW +: OPW] = b;
    job.req_x2[k*OPW +: OPW] = c;
    job.req_y2[k*OPW +: OPW] = d;
  endtask

  // Leaves the bench on a falling edge with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    job.req_valid = '0;
    job.res_ready = 1'b0;
    core_hang = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    job.req_valid = '0;
    job.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (job.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready: got %b want 0000", job.req_ready); end
    total++; if (job.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid: got %b want 0", job.res_valid); end
    total++; if (job.res_err !== 1'b0) begin bad++; $display("FAIL reset_res_err: got %b want 0", job.res_err); end
    total++; if (job.res_id !== 2'd0) begin bad++; $display("FAIL reset_res_id: got %0d want 0", job.res_id); end
    total++; if (job.res_data !== '0) begin bad++; $display("FAIL reset_res_data: got %0h want 0", job.res_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (core_reset !== 1'b1) begin bad++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    total++; if ((core_x1 | core_y1 | core_x2 | core_y2) !== '0) begin bad++; $display("FAIL reset_core_ops: got nonzero/X operands want 0"); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int t = 0;
    bit seen = 0;
    do_reset();
    job.res_ready = 1'b1;
    set_ops(2, OPW'(5), '0, '0, '0);
    job.req_valid = 4'b0100;
    #1;
    total++; if (job.req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", job.req_ready); end
    while (!seen && t < 60) begin
      @(negedge clk);
      job.req_valid = '0;
      #1;
      t++;
      if (t == 1) begin
        total++; if (core_reset !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_start: core_reset=%b busy=%b want 1 1", core_reset, busy); end
      end
      if (t == 2) begin
        total++; if (core_reset !== 1'b0) begin bad++; $display("FAIL single_run_core_reset: got %b want 0", core_reset); end
      end
      if (job.res_valid === 1'b1) seen = 1;
    end
    total++; if (t != 23) begin bad++; $display("FAIL single_latency: got %0d want 23", t); end
    total++; if (job.res_id !== 2'd2) begin bad++; $display("FAIL single_res_id: got %0d want 2", job.res_id); end
    total++; if (job.res_data !== (W6+1)'(5)) begin bad++; $display("FAIL single_res_data: got %0h want 5", job.res_data); end
    total++; if (job.res_err !== 1'b0) begin bad++; $display("FAIL single_res_err: got %b want 0", job.res_err); end
    @(negedge clk);
    #1;
    total++; if (busy !== 1'b0 || job.res_valid !== 1'b0) begin bad++; $display("FAIL single_idle_after: busy=%b res_valid=%b want 0 0", busy, job.res_valid); end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [W6:0] dat[4];
    int grants = 0;
    int results = 0;
    do_reset();
    for (int k = 0; k < N; k++) begin
      logic [WIDTH:0] a, b, c, d;
      a = rand_op(); b = rand_op(); c = rand_op(); d = rand_op();
      set_ops(k, a, b, c, d);
      dat[k] = {{(W6-WIDTH){1'b0}}, a ^ b ^ c ^ d};
    end
    job.res_ready = 1'b1;
    job.req_valid = 4'b1111;
    for (int cyc = 0; cyc < 300 && (grants < 5 || results < 4); cyc++) begin
      #1;
      if (job.req_ready !== 4'b0000 && grants < 5) begin
        total++; if (job.req_ready !== (4'b0001 << order[grants])) begin bad++; $display("FAIL rr_grant%0d: got %b want bit %0d", grants, job.req_ready, order[grants]); end
        grants++;
      end
      if (job.res_valid === 1'b1 && results < 4) begin
        total++; if (job.res_id !== IDW'(results) || job.res_data !== dat[results]) begin bad++; $display("FAIL rr_result%0d: got id %0d want id %0d (or data differs)", results, job.res_id, results); end
        results++;
      end
      @(negedge clk);
    end
    total++; if (grants != 5 || results != 4) begin bad++; $display("FAIL rr_progress: got grants=%0d results=%0d want 5 4", grants, results); end
  endtask

  task automatic test_operand_stability();
    logic [WIDTH:0] a, b, c, d;
    logic [W6:0] expd;
    bit seen = 0;
    do_reset();
    a = rand_op(); b = rand_op(); c = rand_op(); d = rand_op();
    expd = {{(W6-WIDTH){1'b0}}, a ^ b ^ c ^ d};
    set_ops(1, a, b, c, d);
    job.res_ready = 1'b1;
    job.req_valid = 4'b0010;
    #1;
    total++; if (job.req_ready !== 4'b0010) begin bad++; $display("FAIL stab_grant: got %b want 0010", job.req_ready); end
    for (int t = 1; t < 60 && !seen; t++) begin
      @(negedge clk);
      job.req_valid = '0;
      if (t == 4) job.req_x2[1*OPW +: OPW] = ~c;
      #1;
      if (job.res_valid === 1'b1) begin
        seen = 1;
        total++; if (job.res_data !== expd) begin bad++; $display("FAIL stab_result: result differs from captured operands"); end
      end else if (t >= 2) begin
        total++; if (core_x2 !== c || core_x1 !== a || core_y1 !== b || core_y2 !== d) begin bad++; $display("FAIL stab_core_ops cycle %0d: core operands changed during RUN", t); end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL stab_timeout: got no result want one"); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] a;
    logic [W6:0] expd;
    bit seen = 0;
    do_reset();
    a = rand_op();
    expd = {{(W6-WIDTH){1'b0}}, a};
    set_ops(0, a, '0, '0, '0);
    set_ops(3, rand_op(), rand_op(), rand_op(), rand_op());
    job.req_valid = 4'b0001;
    #1;
    total++; if (job.req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant: got %b want 0001", job.req_ready); end
    for (int t = 1; t < 60 && !seen; t++) begin
      @(negedge clk);
      job.req_valid = 4'b1000;
      #1;
      total++; if (job.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_busy_grant: got %b want 0000", job.req_ready); end
      if (job.res_valid === 1'b1) seen = 1;
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_timeout: got no result want one"); end
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      #1;
      total++; if (job.res_valid !== 1'b1 || job.res_id !== 2'd0 || job.res_data !== expd || job.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_hold%0d: res_valid=%b res_id=%0d req_ready=%b want 1 0 0000 with data held", t, job.res_valid, job.res_id, job.req_ready); end
    end
    @(negedge clk);
    job.res_ready = 1'b1;
    #1;
    total++; if (job.req_ready !== 4'b0000) begin bad++; $display("FAIL bp_handshake_grant: got %b want 0000", job.req_ready); end
    @(negedge clk);
    job.res_ready = 1'b0;
    #1;
    total++; if (job.req_ready !== 4'b1000 || job.res_valid !== 1'b0) begin bad++; $display("FAIL bp_next_grant: req_ready=%b res_valid=%b want 1000 0", job.req_ready, job.res_valid); end
  endtask

  task automatic test_reset_mid_job();
    bit got = 0;
    do_reset();
    set_ops(3, rand_op(), rand_op(), rand_op(), rand_op());
    job.res_ready = 1'b1;
    job.req_valid = 4'b1000;
    #1;
    total++; if (job.req_ready !== 4'b1000) begin bad++; $display("FAIL rst_mid_grant: got %b want 1000", job.req_ready); end
    for (int t = 1; t <= 6; t++) begin
      @(negedge clk);
      job.req_valid = '0;
      #1;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || core_reset !== 1'b1 || job.res_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_state: busy=%b core_reset=%b res_valid=%b want 0 1 0", busy, core_reset, job.res_valid); end
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      #1;
      if (job.res_valid === 1'b1) got = 1;
    end
    total++; if (got) begin bad++; $display("FAIL rst_mid_no_result: got a result want none"); end
  endtask

`ifdef PAIRING_TIMEOUT_EN
  task automatic test_watchdog();
    int t = 0;
    bit seen = 0;
    do_reset();
    core_hang = 1'b1;
    set_ops(1, rand_op(), rand_op(), rand_op(), rand_op());
    job.res_ready = 1'b1;
    job.req_valid = 4'b0010;
    #1;
    total++; if (job.req_ready !== 4'b0010) begin bad++; $display("FAIL wd_grant: got %b want 0010", job.req_ready); end
    while (!seen && t < 60) begin
      @(negedge clk);
      job.req_valid = '0;
      #1;
      t++;
      if (job.res_valid === 1'b1) seen = 1;
    end
    total++; if (t != 10) begin bad++; $display("FAIL wd_latency: got %0d want 10", t); end
    total++; if (job.res_err !== 1'b1 || job.res_data !== '0 || job.res_id !== 2'd1) begin bad++; $display("FAIL wd_result: res_err=%b res_id=%0d want 1 1 with zero data", job.res_err, job.res_id); end
    @(negedge clk);
    core_hang = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] pend = '0;
    logic [W6:0]  dat[N];
    int           exp_id[$];
    logic [W6:0]  exp_dat[$];
    int           ptr = 0;
    bit           active = 0;
    int           wait_cnt = 0;
    int           results = 0;
    int           g;
    logic [N-1:0] exp_g;
    do_reset();
    for (int step = 0; step < 900; step++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          logic [WIDTH:0] a, b, c, d;
          a = rand_op(); b = rand_op(); c = rand_op(); d = rand_op();
          set_ops(k, a, b, c, d);
          dat[k] = {{(W6-WIDTH){1'b0}}, a ^ b ^ c ^ d};
          pend[k] = 1'b1;
        end else if (pend[k] && $urandom_range(0, 31) == 0) begin
          pend[k] = 1'b0;
        end
      end
      job.req_valid = pend;
      job.res_ready = ($urandom_range(0, 2) != 0);
      #1;
      g = (!active && pend != '0) ? rr_expect(pend, ptr) : -1;
      exp_g = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      total++; if (job.req_ready !== exp_g) begin bad++; $display("FAIL rand_grant step %0d: got %b want %b", step, job.req_ready, exp_g); end
      if (g >= 0) begin
        exp_id.push_back(g);
        exp_dat.push_back(dat[g]);
        ptr = (g + 1) % N;
        active = 1;
        pend[g] = 1'b0;
      end
      if (job.res_valid === 1'b1 && job.res_ready === 1'b1) begin
        if (exp_id.size() == 0) begin
          total++; bad++; $display("FAIL rand_unexpected step %0d: got result id %0d want none", step, job.res_id);
        end else begin
          total++; if (job.res_id !== IDW'(exp_id[0]) || job.res_data !== exp_dat[0] || job.res_err !== 1'b0) begin bad++; $display("FAIL rand_result step %0d: got id %0d want id %0d (or data/err differs)", step, job.res_id, exp_id[0]); end
          void'(exp_id.pop_front());
          void'(exp_dat.pop_front());
        end
        results++;
        active = 0;
        wait_cnt = 0;
      end
      if (active) wait_cnt++;
      if (wait_cnt > 200) begin
        total++; bad++; $display("FAIL rand_stall step %0d: got no result within 200 cycles", step);
        break;
      end
      @(negedge clk);
    end
    total++; if (results < 10) begin bad++; $display("FAIL rand_throughput: got %0d results want at least 10", results); end
  endtask

  initial begin
    reset = 1'b1;
    job.req_valid = '0;
    job.res_ready = 1'b0;
    job.req_x1 = '0;
    job.req_y1 = '0;
    job.req_x2 = '0;
    job.req_y2 = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_operand_stability();
    test_backpressure();
    test_reset_mid_job();
`ifdef PAIRING_TIMEOUT_EN
    test_watchdog();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pairing_job_arbiter.md
# pairing_job_arbiter

Shares one `tate_pairing` core among `N_REQ` requesters. Round-robin arbitration, operand capture and hold, core restart sequencing, and result return with requester ID and backpressure. It sits between the host-side job ports and the single pairing core instance. The core is strictly one job at a time; there is no pipelining inside it.

## Interface
Parameters:
- `N_REQ`, 4: number of requester ports, 2..8.
- `ID_W`, 2: width of the requester ID, clog2(`N_REQ`), minimum 1.
- `TIMEOUT_CYCLES`, 65535: watchdog limit in RUN. Used only with `PAIRING_TIMEOUT_EN`.

Ports (`WIDTH`/`W6` from `inc.v`):
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `N_REQ`: per-requester job request.
- `req_ready` out `N_REQ`: one-hot grant/accept pulse.
- `req_x1`, `req_y1`, `req_x2`, `req_y2` in `N_REQ*(WIDTH+1)` each: flattened operands; slice k belongs to requester k.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_id` out `ID_W`: requester index of the result.
- `res_data` out `W6+1`: pairing value.
- `res_err` out 1: job aborted by the watchdog.
- `busy` out 1: a job is held (any state other than IDLE).
- `core_reset` out 1: drives the core reset.
- `core_x1`, `core_y1`, `core_x2`, `core_y2` out `WIDTH+1`: core operands.
- `core_done` in 1: core done.
- `core_out` in `W6+1`: core result.

## Operation
FSM states: IDLE, START, RUN, RESP.
- **IDLE**
  - `core_reset`=1, so the core is parked.
  - If any `req_valid` is set, grant the first set bit at or after `rr_ptr`, wrapping modulo `N_REQ`.
  - In the same cycle: `req_ready[g]`=1, capture that requester's four operands and g into registers, set `rr_ptr`←(g+1) mod `N_REQ`, go to START.
- **START**
  - `core_reset`=1 for exactly this cycle, with the captured operands already driven.
  - Go to RUN.
- **RUN**
  - `core_reset`=0.
  - Captured operands stay stable on `core_*` for the whole state. The core reads `x2`/`y2` continuously, so any change corrupts the result.
  - On `core_done`=1: register `res_data`←`core_out`, `res_err`←0, go to RESP.
- **RESP**
  - `res_valid`=1 and `core_reset`=1.
  - `res_id`, `res_data`, `res_err` are held stable until `res_valid`&`res_ready`, then go to IDLE.
- General rules:
  - At most one `req_ready` bit is high, and only in IDLE.
  - A requester dropping `req_valid` before it is granted is legal; its request is simply lost.
  - `core_done` is ignored outside RUN. It is stale from the previous job until the core reset clears it.
  - Reset mid-job: the FSM returns to IDLE and the job is dropped silently; no response is produced. `core_reset` goes to 1 immediately, which also restarts the core.

## Timing
Reset values:
- `req_ready`=0, `res_valid`=0, `res_err`=0, `res_id`=0, `res_data`=0.
- `busy`=0, `core_reset`=1, `rr_ptr`=0.
- `core_*` operands = 0.

Latencies:
- Accept in cycle T; START in T+1; `core_reset` falls at T+2.
- `core_done` seen in cycle D gives `res_valid`=1 from D+1.
- Result handshake in cycle R gives IDLE at R+1. The earliest next `req_ready` is R+1.
- With no backpressure, one job occupies (core latency + 3) cycles.

## Configuration
Macro `PAIRING_TIMEOUT_EN`.
- **Defined:**
  - A 16-to-32-bit counter, sized from `TIMEOUT_CYCLES`, clears on entry to RUN and increments each RUN cycle.
  - When it reaches `TIMEOUT_CYCLES`-1 without `core_done`, go to RESP with `res_err`=1 and `res_data`=0.
  - If `core_done` arrives in that same cycle, `core_done` wins and `res_err`=0.
- **Undefined:** no counter, `res_err` is tied 0, and RUN waits indefinitely.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, START=2'd1, RUN=2'd2, RESP=2'd3.
  - Default `TIMEOUT_CYCLES`.
- The round-robin picker is its own sub-module, `rr_pick`:
  - Combinational; inputs `req` and `ptr`, outputs one-hot `grant` and index `gidx`.
  - Reusable by other shared F3m resources.

## Test plan
All scenarios use `N_REQ`=4 and a core model with `done` 20 cycles after reset falls and `out`=x1^y1^x2^y2 zero-extended.
- **Single request.** Request 2 only, x1=5 (others 0), `res_ready`=1 → `req_ready`=4'b0100 one cycle; `res_valid` 23 cycles after accept; `res_id`=2, `res_data`=5.
- **All requesters.** All 4 valid continuously → grants in order 0,1,2,3,0; `res_id` sequence 0,1,2,3.
- **Operand stability.** Change `req_x2` of the granted requester during RUN → `core_x2` unchanged; result matches the captured value.
- **Backpressure.** `res_ready`=0 for 10 cycles after `res_valid` → outputs stable; no `req_ready`; grant occurs in the cycle after the handshake.
- **Reset mid-job.** `reset` asserted in RUN cycle 5 → next cycle `busy`=0, `core_reset`=1, `res_valid`=0; no result is ever delivered for that job.
- **Watchdog** (`PAIRING_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, core never done) → `res_valid` with `res_err`=1 and `res_data`=0, 8 cycles after entering RUN.
